// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants for the RTC bus driver.
// State encoding, default phase timing and operation encoding.
package rtc_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_A_SETUP  = 3'd1;
    localparam logic [2:0] S_A_STROBE = 3'd2;
    localparam logic [2:0] S_A_HOLD   = 3'd3;
    localparam logic [2:0] S_D_SETUP  = 3'd4;
    localparam logic [2:0] S_D_STROBE = 3'd5;
    localparam logic [2:0] S_D_HOLD   = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam int T_SETUP_DEF = 2;
    localparam int T_PULSE_DEF = 8;
    localparam int T_GAP_DEF   = 4;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: loadable 8-bit down-counter with zero flag.
// Ports: i_clk, i_rst (sync, high), i_load, i_load_val[7:0] in;
//        o_zero out (count == 0).
module rtc_phase_timer (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_zero
);

    logic [7:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/rtc_bus_driver.sv
// rtc_bus_driver: turns level-held win/rin requests into an RTC
// multiplexed A/D bus cycle (address phase, then data phase).
// Ports in : clock, reset (sync, high), win, rin, address[7:0],
//            data_in[7:0], ad_in[7:0].
// Ports out: ad_out[7:0], ad_oe, ad_sel, cs_n, wr_n, rd_n,
//            rdata[7:0], donew, doner, busy. All registered.
module rtc_bus_driver
    import rtc_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_GAP   = T_GAP_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       win,
    input  logic       rin,
    input  logic [7:0] address,
    input  logic [7:0] data_in,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ad_sel,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] rdata,
    output logic       donew,
    output logic       doner,
    output logic       busy
);

    localparam logic [7:0] L_SETUP = 8'(T_SETUP - 1);
    localparam logic [7:0] L_PULSE = 8'(T_PULSE - 1);
    localparam logic [7:0] L_GAP   = 8'(T_GAP - 1);

    logic [2:0] r_state;
    logic       r_op;
    logic [7:0] r_addr;
    logic [7:0] r_data;

    logic [2:0] w_next;
    logic       w_start;
    logic       w_zero;
    logic       w_load;
    logic [7:0] w_load_val;
    logic       w_op;
    logic [7:0] w_addr;
    logic [7:0] w_data;

    logic [7:0] w_ad_out;
    logic       w_ad_oe;
    logic       w_ad_sel;
    logic       w_cs_n;
    logic       w_wr_n;
    logic       w_rd_n;
    logic       w_donew;
    logic       w_doner;

    assign w_start = (r_state == S_IDLE) && (win || rin);

    // Outputs are decoded from the next state so that the
    // registered pins line up with the state they belong to.
    assign w_op   = w_start ? (win ? OP_WR : OP_RD) : r_op;
    assign w_addr = w_start ? address : r_addr;
    assign w_data = w_start ? data_in : r_data;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (w_start) w_next = S_A_SETUP;
            S_A_SETUP:  if (w_zero)  w_next = S_A_STROBE;
            S_A_STROBE: if (w_zero)  w_next = S_A_HOLD;
            S_A_HOLD:   if (w_zero)  w_next = S_D_SETUP;
            S_D_SETUP:  if (w_zero)  w_next = S_D_STROBE;
            S_D_STROBE: if (w_zero)  w_next = S_D_HOLD;
            S_D_HOLD:   if (w_zero)  w_next = S_DONE;
            default:                 w_next = S_IDLE;
        endcase
    end

    // Every transition enters a new state, so reload on change.
    assign w_load = (w_next != r_state);

    always_comb begin
        w_load_val = 8'd0;
        unique case (w_next)
            S_A_SETUP,  S_D_SETUP:  w_load_val = L_SETUP;
            S_A_STROBE, S_D_STROBE: w_load_val = L_PULSE;
            S_A_HOLD,   S_D_HOLD:   w_load_val = L_GAP;
            default:                w_load_val = 8'd0;
        endcase
    end

    rtc_phase_timer u_timer (
        .i_clk      (clock),
        .i_rst      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_ad_out = 8'd0;
        w_ad_oe  = 1'b0;
        w_ad_sel = 1'b1;
        w_cs_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_rd_n   = 1'b1;
        w_donew  = 1'b0;
        w_doner  = 1'b0;
        unique case (w_next)
            S_A_SETUP, S_A_HOLD: begin
                w_ad_sel = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr;
            end
            // Address latch is always clocked by wr_n.
            S_A_STROBE: begin
                w_ad_sel = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr;
                w_cs_n   = 1'b0;
                w_wr_n   = 1'b0;
            end
            // Reads release the bus here, before rd_n falls.
            S_D_SETUP, S_D_HOLD: begin
                if (w_op == OP_WR) begin
                    w_ad_oe  = 1'b1;
                    w_ad_out = w_data;
                end
            end
            S_D_STROBE: begin
                w_cs_n = 1'b0;
                if (w_op == OP_WR) begin
                    w_ad_oe  = 1'b1;
                    w_ad_out = w_data;
                    w_wr_n   = 1'b0;
                end else begin
                    w_rd_n = 1'b0;
                end
            end
            S_DONE: begin
                w_donew = (w_op == OP_WR);
                w_doner = (w_op == OP_RD);
            end
            default: begin
                w_ad_sel = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_RD;
            r_addr  <= 8'd0;
            r_data  <= 8'd0;
            ad_out  <= 8'd0;
            ad_oe   <= 1'b0;
            ad_sel  <= 1'b1;
            cs_n    <= 1'b1;
            wr_n    <= 1'b1;
            rd_n    <= 1'b1;
            donew   <= 1'b0;
            doner   <= 1'b0;
            busy    <= 1'b0;
            rdata   <= 8'd0;
        end else begin
            r_state <= w_next;
            r_op    <= w_op;
            r_addr  <= w_addr;
            r_data  <= w_data;
            ad_out  <= w_ad_out;
            ad_oe   <= w_ad_oe;
            ad_sel  <= w_ad_sel;
            cs_n    <= w_cs_n;
            wr_n    <= w_wr_n;
            rd_n    <= w_rd_n;
            donew   <= w_donew;
            doner   <= w_doner;
            busy    <= (w_next != S_IDLE);
            // Capture on the last strobe clock, rd_n still low.
            if (r_state == S_D_STROBE && w_zero && r_op == OP_RD) begin
                rdata <= ad_in;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_driver.sv
// tb_rtc_bus_driver: directed bench for rtc_bus_driver.
// RTC pad model returns 8'h16 while rd_n is low.
module tb_rtc_bus_driver;

    logic       clock;
    logic       reset;
    logic       win;
    logic       rin;
    logic [7:0] address;
    logic [7:0] data_in;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       ad_sel;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] rdata;
    logic       donew;
    logic       doner;
    logic       busy;

    rtc_bus_driver dut (
        .clock   (clock),
        .reset   (reset),
        .win     (win),
        .rin     (rin),
        .address (address),
        .data_in (data_in),
        .ad_in   (ad_in),
        .ad_out  (ad_out),
        .ad_oe   (ad_oe),
        .ad_sel  (ad_sel),
        .cs_n    (cs_n),
        .wr_n    (wr_n),
        .rd_n    (rd_n),
        .rdata   (rdata),
        .donew   (donew),
        .doner   (doner),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign ad_in = (!rd_n) ? 8'h16 : 8'hA5;

    int n_cmp = 0;
    int n_err = 0;

    int n_awr, n_dwr, n_rd, n_conf, n_roe;
    int n_abad, n_dbad, n_dw, n_dr;
    logic [7:0] exp_addr, exp_data;
    logic       exp_wr;
    logic       prev_wr_n = 1'b1;
    logic [7:0] aq[$];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_awr = 0; n_dwr = 0; n_rd = 0; n_conf = 0; n_roe = 0;
        n_abad = 0; n_dbad = 0; n_dw = 0; n_dr = 0;
    endtask

    task automatic sample();
        if (!wr_n && !ad_sel) begin
            n_awr++;
            if (ad_out != exp_addr) n_abad++;
            if (prev_wr_n) aq.push_back(ad_out);
        end
        if (!wr_n && ad_sel) begin
            n_dwr++;
            if (ad_out != exp_data) n_dbad++;
        end
        if (!rd_n) begin
            n_rd++;
            if (ad_oe) n_conf++;
        end
        if (ad_sel && busy && ad_oe && !exp_wr) n_roe++;
        if (donew) n_dw++;
        if (doner) n_dr++;
        prev_wr_n = wr_n;
    endtask

    task automatic req(input logic w, input logic r,
                       input logic [7:0] a, input logic [7:0] d);
        win = w;
        rin = r;
        address = a;
        data_in = d;
        exp_addr = a;
        exp_data = d;
        exp_wr = w;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            sample();
            if (donew || doner) begin
                cyc = i + 1;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            sample();
        end
    endtask

    int cyc;

    initial begin
        reset = 1'b1;
        win = 1'b0;
        rin = 1'b0;
        address = 8'h00;
        data_in = 8'h00;
        exp_addr = 8'h00;
        exp_data = 8'h00;
        exp_wr = 1'b1;
        clr();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle(10);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_wr_n", 32'(wr_n), 32'd1);
        chk("rst_rd_n", 32'(rd_n), 32'd1);
        chk("rst_ad_oe", 32'(ad_oe), 32'd0);
        chk("rst_ad_sel", 32'(ad_sel), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ad_out", 32'(ad_out), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_dones", 32'(n_dw + n_dr), 32'd0);

        clr();
        req(1'b1, 1'b0, 8'h21, 8'h45);
        wait_done(cyc);
        win = 1'b0;
        chk("wr_lat", 32'(cyc), 32'd29);
        idle(4);
        chk("wr_a_lo", 32'(n_awr), 32'd8);
        chk("wr_a_val", 32'(n_abad), 32'd0);
        chk("wr_d_lo", 32'(n_dwr), 32'd8);
        chk("wr_d_val", 32'(n_dbad), 32'd0);
        chk("wr_donew", 32'(n_dw), 32'd1);
        chk("wr_doner", 32'(n_dr), 32'd0);
        chk("wr_no_rd", 32'(n_rd), 32'd0);
        chk("wr_idle", 32'(busy), 32'd0);

        clr();
        req(1'b0, 1'b1, 8'h26, 8'h00);
        wait_done(cyc);
        rin = 1'b0;
        chk("rd_lat", 32'(cyc), 32'd29);
        idle(4);
        chk("rd_rdata", 32'(rdata), 32'h16);
        chk("rd_a_lo", 32'(n_awr), 32'd8);
        chk("rd_a_val", 32'(n_abad), 32'd0);
        chk("rd_rd_lo", 32'(n_rd), 32'd8);
        chk("rd_conf", 32'(n_conf), 32'd0);
        chk("rd_oe", 32'(n_roe), 32'd0);
        chk("rd_no_dwr", 32'(n_dwr), 32'd0);
        chk("rd_doner", 32'(n_dr), 32'd1);
        chk("rd_donew", 32'(n_dw), 32'd0);

        clr();
        req(1'b1, 1'b1, 8'h30, 8'h5A);
        wait_done(cyc);
        chk("both_lat", 32'(cyc), 32'd29);
        chk("both_donew", 32'(n_dw), 32'd1);
        chk("both_doner", 32'(n_dr), 32'd0);
        chk("both_dwr", 32'(n_dwr), 32'd8);
        clr();
        req(1'b0, 1'b1, 8'h31, 8'h00);
        wait_done(cyc);
        rin = 1'b0;
        chk("chain_lat", 32'(cyc), 32'd30);
        chk("chain_doner", 32'(n_dr), 32'd1);
        chk("chain_rd_lo", 32'(n_rd), 32'd8);
        chk("chain_a_val", 32'(n_abad), 32'd0);
        idle(4);

        clr();
        aq.delete();
        req(1'b1, 1'b0, 8'h40, 8'h77);
        for (int i = 0; i < 17; i++) begin
            wait_done(cyc);
            chk($sformatf("b2b_lat%0d", i), 32'(cyc),
                (i == 0) ? 32'd29 : 32'd30);
            if (i < 16) req(1'b1, 1'b0, 8'(8'h41 + i), 8'h77);
            else win = 1'b0;
        end
        idle(4);
        chk("b2b_donew", 32'(n_dw), 32'd17);
        chk("b2b_a_val", 32'(n_abad), 32'd0);
        chk("b2b_qsize", 32'(aq.size()), 32'd17);
        for (int i = 0; i < 17; i++) begin
            if (i < aq.size())
                chk($sformatf("b2b_addr%0d", i), 32'(aq[i]),
                    32'(8'h40 + i));
        end

        clr();
        req(1'b1, 1'b0, 8'h52, 8'h63);
        cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            sample();
            if (ad_sel && !wr_n) begin
                cyc = i;
                break;
            end
        end
        chk("rst_mid_reach", 32'(cyc >= 0), 32'd1);
        reset = 1'b1;
        win = 1'b0;
        @(negedge clock);
        chk("rst_mid_cs_n", 32'(cs_n), 32'd1);
        chk("rst_mid_wr_n", 32'(wr_n), 32'd1);
        chk("rst_mid_rd_n", 32'(rd_n), 32'd1);
        chk("rst_mid_oe", 32'(ad_oe), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        idle(35);
        chk("rst_mid_donew", 32'(n_dw), 32'd0);
        chk("rst_mid_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
